// File: rtl/bram_access_ctrl_pkg.sv
// Shared definitions for the BRAM access controller: RMW FSM encoding and byte-enable constants.
package bram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } ctrlState_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/bram_access_ctrl_be_merge.sv
// Combinational byte-lane merge: each enabled lane takes the new word, others keep the old word.
module bram_be_merge (
  input  logic [31:0] oldWord,
  input  logic [31:0] newWord,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = newWord[8*b +: 8];
    end
  end

endmodule

// File: rtl/bram_access_ctrl.sv
// Arbitrates one simple-dual-port BRAM between instruction fetch (port 0) and data (port 1),
// with read-modify-write for partial stores. Optional stall counters under `BRAM_CTRL_STATS_EN.
module bram_access_ctrl
  import bram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_be,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] bram_raddr,
  input  logic [31:0]       bram_rdata,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_waddr,
  output logic [31:0]       bram_wdata,
  output logic [31:0]       p0_stall_cnt,
  output logic [31:0]       p1_stall_cnt
);

  ctrlState_t state, stateNext;
  logic              rrPtr;
  logic [ADDR_W-1:0] rmwAddr;
  logic [3:0]        rmwBe;
  logic [31:0]       rmwWdata;
  logic [31:0]       mergedWord;
  logic              p0Vld_p1, p1Vld_p1;
  logic [31:0]       p0Hold, p1Hold;

  logic p1Write, p1Full, p1Null, p1Partial, p1RdUser;
  logic contested, grant0, grant1Rd;

  // Full writes own port A and never compete; everything else shares port B.
  always_comb begin
    p1Write   = p1_req & p1_we;
    p1Full    = p1Write & (p1_be == BE_FULL);
    p1Null    = p1Write & (p1_be == BE_NONE);
    p1Partial = p1Write & ~p1Full & ~p1Null;
    p1RdUser  = (p1_req & ~p1_we) | p1Partial;
    contested = p0_req & p1RdUser;
    grant0    = p0_req & ~(contested & rrPtr);
    grant1Rd  = p1RdUser & ~(contested & ~rrPtr);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grant1Rd & p1Partial) stateNext = RMW_RD;
      RMW_RD:  stateNext = RMW_WR;
      RMW_WR:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    bram_we    = 1'b0;
    bram_raddr = p0_addr;
    bram_waddr = p1_addr;
    bram_wdata = p1_wdata;
    case (state)
      IDLE: begin
        if (!rst) begin
          p0_ready = grant0;
          p1_ready = grant1Rd | p1Full | p1Null;
          bram_we  = p1Full;
        end
        if (grant1Rd) bram_raddr = p1_addr;
      end
      RMW_RD: bram_raddr = rmwAddr;
      RMW_WR: begin
        bram_raddr = rmwAddr;
        bram_waddr = rmwAddr;
        bram_wdata = mergedWord;
        bram_we    = ~rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr <= 1'b0;
    end else if (state == IDLE && contested) begin
      rrPtr <= ~rrPtr;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && grant1Rd && p1Partial) begin
      rmwAddr  <= p1_addr;
      rmwBe    <= p1_be;
      rmwWdata <= p1_wdata;
    end
  end

  bram_be_merge uMerge (
    .oldWord (bram_rdata),
    .newWord (rmwWdata),
    .be      (rmwBe),
    .merged  (mergedWord)
  );

  // ---- stage p1: BRAM port B data returns; hold last word for idle cycles ----
  always_ff @(posedge clk) begin
    if (rst) begin
      p0Vld_p1 <= 1'b0;
      p1Vld_p1 <= 1'b0;
      p0Hold   <= 32'd0;
      p1Hold   <= 32'd0;
    end else begin
      p0Vld_p1 <= p0_ready;
      p1Vld_p1 <= p1_ready & ~p1_we;
      if (p0Vld_p1) p0Hold <= bram_rdata;
      if (p1Vld_p1) p1Hold <= bram_rdata;
    end
  end

  assign p0_rvalid = p0Vld_p1;
  assign p1_rvalid = p1Vld_p1;
  assign p0_rdata  = p0Vld_p1 ? bram_rdata : p0Hold;
  assign p1_rdata  = p1Vld_p1 ? bram_rdata : p1Hold;

`ifdef BRAM_CTRL_STATS_EN
  logic [31:0] stall0, stall1;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall0 <= 32'd0;
      stall1 <= 32'd0;
    end else begin
      if (p0_req && !p0_ready) stall0 <= satInc(stall0);
      if (p1_req && !p1_ready) stall1 <= satInc(stall1);
    end
  end

  assign p0_stall_cnt = stall0;
  assign p1_stall_cnt = stall1;
`else
  assign p0_stall_cnt = 32'd0;
  assign p1_stall_cnt = 32'd0;
`endif

endmodule
